// File: rtl/apb_bridge_arbiter.sv
// Round-robin bridge from two requesters onto one APB master port; min 4 cycles per transfer (IDLE, SETUP, ACCESS, DONE).
// Requests wait, holding their fields, until ready is high in IDLE. The slave stalls via pready, bounded by TIMEOUT ACCESS cycles.
module apb_bridge_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic       req0_write,
   input  logic [6:0] req0_addr,
   input  logic [7:0] req0_wdata,
   output logic       req0_ready,
   output logic       req0_done,
   output logic [7:0] req0_rdata,
   output logic       req0_err,
   input  logic       req1_valid,
   input  logic       req1_write,
   input  logic [6:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic       req1_ready,
   output logic       req1_done,
   output logic [7:0] req1_rdata,
   output logic       req1_err,
   output logic       psel,
   output logic       penable,
   output logic       pwrite,
   output logic [6:0] paddr,
   output logic [7:0] pwdata,
   input  logic [7:0] prdata,
   input  logic       pready,
   input  logic       pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     r_state;
   logic       r_last_grant;
   logic       r_owner;
   logic [7:0] r_wait;

   logic       w_idle;
   logic       w_grant0;
   logic       w_grant1;
   logic       w_timeout;
   logic       w_finish;
   logic [7:0] w_rdata;
   logic       w_err;

   // On a tie the requester that did not win last time gets the bus.
   assign w_idle    = (r_state == IDLE);
   assign w_grant0  = w_idle && req0_valid && (!req1_valid || r_last_grant);
   assign w_grant1  = w_idle && req1_valid && (!req0_valid || !r_last_grant);
   assign w_timeout = (r_wait == LP_WAIT_LAST);
   assign w_finish  = pready || w_timeout;
   assign w_rdata   = (pready && !pwrite) ? prdata : 8'h00;
   assign w_err     = pready ? pslverr : 1'b1;

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_wait       <= 8'h00;
         psel         <= 1'b0;
         penable      <= 1'b0;
         pwrite       <= 1'b0;
         paddr        <= 7'h00;
         pwdata       <= 8'h00;
         req0_done    <= 1'b0;
         req0_rdata   <= 8'h00;
         req0_err     <= 1'b0;
         req1_done    <= 1'b0;
         req1_rdata   <= 8'h00;
         req1_err     <= 1'b0;
      end else begin
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant0 || w_grant1) begin
                  r_owner      <= w_grant1;
                  r_last_grant <= w_grant1;
                  psel         <= 1'b1;
                  penable      <= 1'b0;
                  pwrite       <= w_grant1 ? req1_write : req0_write;
                  paddr        <= w_grant1 ? req1_addr  : req0_addr;
                  pwdata       <= w_grant1 ? req1_wdata : req0_wdata;
                  r_wait       <= 8'h00;
                  r_state      <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               r_state <= ACCESS;
            end
            ACCESS: begin
               // pready on the last allowed cycle completes normally.
               if (w_finish) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  r_state <= DONE;
                  if (r_owner) begin
                     req1_done  <= 1'b1;
                     req1_rdata <= w_rdata;
                     req1_err   <= w_err;
                  end else begin
                     req0_done  <= 1'b1;
                     req0_rdata <= w_rdata;
                     req0_err   <= w_err;
                  end
               end else begin
                  r_wait <= r_wait + 8'h01;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_bridge_arbiter.md
APB_BRIDGE_ARBITER -- requirements
Module: apb_bridge_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: ACCESS-phase cycles allowed without PREADY before abort (legal 1..255).
REQ-002 The block SHALL have ports:
  clk  in  1  sole clock, all state updates on rising edge
  rst  in  1  reset, synchronous, active-low
  req0_valid  in  1  requester 0 (I2C side) transaction request
  req0_write  in  1  1=write, 0=read
  req0_addr  in  7  target address
  req0_wdata  in  8  write data
  req0_ready  out  1  request 0 accepted this cycle
  req0_done  out  1  one-cycle completion pulse
  req0_rdata  out  8  read data, valid with req0_done
  req0_err  out  1  error flag, valid with req0_done
  req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata, req1_err  same as req0, for requester 1 (config port)
  psel  out  1  APB select
  penable  out  1  APB enable
  pwrite  out  1  APB direction
  paddr  out  7  APB address
  pwdata  out  8  APB write data
  prdata  in  8  APB read data
  pready  in  1  APB slave ready
  pslverr  in  1  APB slave error

Function
REQ-003 FSM states SHALL be IDLE, SETUP, ACCESS, DONE; reset state IDLE.
REQ-004 reqN_ready SHALL be combinational: high only in IDLE for the requester the arbiter selects that cycle; at most one ready high per cycle.
REQ-005 Arbitration SHALL be round-robin: one valid -> that requester; both valid -> requester not in last_grant; last_grant resets to 1, so req0 wins the first tie.
REQ-006 On acceptance edge, the block SHALL latch write/addr/wdata and owner, update last_grant, go to SETUP.
REQ-007 SETUP (1 cycle): psel=1, penable=0, pwrite/paddr/pwdata from latched request; then ACCESS.
REQ-008 ACCESS: psel=1, penable=1, all APB outputs held stable; stay until pready=1 or timeout.
REQ-009 On pready=1 in ACCESS, the block SHALL capture prdata (reads only; writes return rdata=0) and pslverr into owner's rdata/err; go DONE.
REQ-010 Wait counter (8 bit) SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0; when pready=0 with counter==TIMEOUT-1, abort: err=1, rdata=0, go DONE.
REQ-011 pready=1 on the timeout cycle SHALL win: normal completion, no timeout error.
REQ-012 DONE (1 cycle): psel=0, penable=0, owner's reqN_done=1, other done=0; then IDLE.
REQ-013 reqN_rdata/reqN_err SHALL hold until that requester's next completion.
REQ-014 Minimum latency: acceptance edge -> done pulse in 3rd following cycle (SETUP, ACCESS with pready=1, DONE); min 4 cycles per transaction incl. IDLE.
REQ-015 Requests SHALL not be accepted outside IDLE; requester holds valid and fields until ready.
REQ-016 psel, penable, pwrite, paddr, pwdata, reqN_done, reqN_rdata, reqN_err SHALL be registered.
REQ-017 Deassertion of reqN_valid after acceptance SHALL not affect the transaction in flight.

Reset
REQ-018 rst=0 at a rising edge SHALL force IDLE, last_grant=1, counter=0, all registered outputs 0.
REQ-019 Reset mid-transaction SHALL drop psel/penable at that edge and issue no done pulse for the aborted transaction.

Verification
REQ-020 req0 write addr=0x12 wdata=0xA5, pready=1 in ACCESS -> SETUP psel=1 penable=0 paddr=0x12 pwdata=0xA5 pwrite=1; next cycle penable=1; next cycle req0_done=1, req0_err=0.
REQ-021 req1 read addr=0x05, pready low 3 ACCESS cycles then high with prdata=0x3C -> req1_done once, req1_rdata=0x3C, req1_err=0, APB signals stable throughout ACCESS.
REQ-022 req0 and req1 valid together continuously after reset -> grants order 0,1,0,1; no cycle with both ready high.
REQ-023 TIMEOUT=4, read with pready always 0 -> exactly 4 ACCESS cycles, then done with err=1, rdata=0x00; block returns to IDLE and accepts next request.
REQ-024 pslverr=1 with pready=1 on a write -> err=1 on done; rst=0 during ACCESS -> psel=penable=0 at that edge, no done pulse, next request served normally.
